// File: rtl/craft_tweakey_scheduler.sv
// CRAFT round-tweakey generator: captures key/tweak on start, then streams TK_r for every
// round in DATA_W-bit beats (MSB nibble first) together with the round index and round constant.
module craft_tweakey_scheduler #(
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned NUM_ROUNDS = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              dec_i,
  input  logic [127:0]      key_i,
  input  logic [63:0]       tweak_i,
  output logic [DATA_W-1:0] tk_data_o,
  output logic              tk_valid_o,
  input  logic              tk_ready_i,
  output logic              tk_first_o,
  output logic              tk_last_o,
  output logic [7:0]        tk_round_o,
  output logic [7:0]        rc_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned Beats     = 64 / DATA_W;
  localparam int unsigned BeatW     = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [BeatW-1:0] LastBeat  = BeatW'(Beats - 1);
  localparam logic [7:0]       LastRound = 8'(NUM_ROUNDS - 1);
  // Nibble j of this constant is the source nibble index for Q(T)[j]
  localparam logic [63:0]      QPerm     = 64'hcaf5e892b374601d;
  // {a, b} = {4'h1, 3'h1}
  localparam logic [6:0]       LfsrInit  = 7'h09;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StStream = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;

  function automatic logic [6:0] lfsr_fwd(input logic [6:0] s);
    logic [3:0] a;
    logic [2:0] b;
    a = s[6:3];
    b = s[2:0];
    return {a[1] ^ a[0], a[3], a[2], a[1], b[1] ^ b[0], b[2], b[1]};
  endfunction

  function automatic logic [6:0] lfsr_inv(input logic [6:0] s);
    logic [3:0] a;
    logic [2:0] b;
    a = s[6:3];
    b = s[2:0];
    return {a[2], a[1], a[0], a[3] ^ a[0], b[1], b[0], b[2] ^ b[0]};
  endfunction

  function automatic logic [6:0] lfsr_fwd_n(input int unsigned n);
    logic [6:0] s;
    s = LfsrInit;
    for (int unsigned i = 0; i < n; i++) s = lfsr_fwd(s);
    return s;
  endfunction

  function automatic logic [63:0] q_perm(input logic [63:0] t);
    logic [63:0] res;
    logic [3:0]  src;
    res = '0;
    for (int j = 0; j < 16; j++) begin
      src = QPerm[63-4*j -: 4];
      res[63-4*j -: 4] = t[63-4*int'(src) -: 4];
    end
    return res;
  endfunction

  // Decryption starts from the last round's constant, folded at elaboration
  localparam logic [6:0] DecInit = lfsr_fwd_n(NUM_ROUNDS - 1);

  logic [1:0]       state_q, state_d;
  logic             dec_q, dec_d;
  logic [63:0]      k0_q, k0_d, k1_q, k1_d, t_q, t_d;
  logic [7:0]       round_q, round_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic [6:0]       lfsr_q, lfsr_d;
  logic             final_round;
  logic [63:0]      tk_cur;
  logic [6:0]       beat_shift;

  assign final_round = dec_q ? (round_q == 8'd0) : (round_q == LastRound);

  // TK_r from captured key/tweak; round bit 0 picks K0/K1, bit 1 picks T or Q(T)
  always_comb begin
    tk_cur = (round_q[0] ? k1_q : k0_q) ^ (round_q[1] ? q_perm(t_q) : t_q);
  end

  assign beat_shift = 7'(64 - DATA_W * (32'(beat_q) + 32'd1));

  // Next-state: capture on start in idle, advance beat/round on each handshake
  always_comb begin
    state_d = state_q;
    dec_d   = dec_q;
    k0_d    = k0_q;
    k1_d    = k1_q;
    t_d     = t_q;
    round_d = round_q;
    beat_d  = beat_q;
    lfsr_d  = lfsr_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StStream;
          dec_d   = dec_i;
          k0_d    = key_i[127:64];
          k1_d    = key_i[63:0];
          t_d     = tweak_i;
          beat_d  = '0;
          round_d = dec_i ? LastRound : 8'd0;
          lfsr_d  = dec_i ? DecInit : LfsrInit;
        end
      end
      StStream: begin
        if (tk_ready_i) begin
          if (beat_q != LastBeat) begin
            beat_d = beat_q + 1'b1;
          end else if (final_round) begin
            state_d = StDone;
          end else begin
            beat_d  = '0;
            round_d = dec_q ? round_q - 8'd1 : round_q + 8'd1;
            lfsr_d  = dec_q ? lfsr_inv(lfsr_q) : lfsr_fwd(lfsr_q);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      dec_q   <= 1'b0;
      k0_q    <= '0;
      k1_q    <= '0;
      t_q     <= '0;
      round_q <= '0;
      beat_q  <= '0;
      lfsr_q  <= LfsrInit;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      k0_q    <= k0_d;
      k1_q    <= k1_d;
      t_q     <= t_d;
      round_q <= round_d;
      beat_q  <= beat_d;
      lfsr_q  <= lfsr_d;
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    tk_valid_o = (state_q == StStream);
    tk_data_o  = '0;
    if (tk_valid_o) tk_data_o = DATA_W'(tk_cur >> beat_shift);
    tk_first_o = tk_valid_o && (beat_q == '0);
    tk_last_o  = tk_valid_o && (beat_q == LastBeat);
    tk_round_o = round_q;
    busy_o     = (state_q != StIdle);
    done_o     = (state_q == StDone);
    rc_o       = busy_o ? {lfsr_q[6:3], 1'b0, lfsr_q[2:0]} : 8'h00;
  end

endmodule

// File: tb/tb_craft_tweakey_scheduler.sv
// Bench for craft_tweakey_scheduler: three configurations run concurrently, each streamed beat
// compared against a queue built from a round-level tweakey/round-constant model.
module tb_craft_tweakey_scheduler;

  typedef struct packed {
    logic [7:0]  round;
    logic [7:0]  rc;
    logic        first;
    logic        last;
    logic [63:0] data;
  } beat_t;

  logic clk;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  int   n_fin    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] q_perm(input logic [63:0] t);
    int p[16] = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};
    logic [63:0] res;
    res = '0;
    for (int j = 0; j < 16; j++) res[63-4*j -: 4] = t[63-4*p[j] -: 4];
    return res;
  endfunction

  function automatic logic [63:0] tk_of(input logic [127:0] k, input logic [63:0] t, input int r);
    logic [63:0] kk, tt;
    kk = (r % 2 == 1) ? k[63:0] : k[127:64];
    tt = (r % 4 < 2) ? t : q_perm(t);
    return kk ^ tt;
  endfunction

  // Round constant of round r: r forward LFSR steps from (1, 1)
  function automatic logic [7:0] rc_of(input int r);
    logic [3:0] a;
    logic [2:0] b;
    a = 4'h1;
    b = 3'h1;
    for (int i = 0; i < r; i++) begin
      a = {a[1] ^ a[0], a[3:1]};
      b = {b[1] ^ b[0], b[2:1]};
    end
    return {a, 1'b0, b};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int unsigned W  = (g == 0) ? 4 : ((g == 1) ? 64 : 16);
    localparam int unsigned NR = (g == 0) ? 32 : ((g == 1) ? 4 : 1);
    localparam int unsigned B  = 64 / W;

    logic         rst, start, dec, ready, stall_en;
    logic [127:0] key;
    logic [63:0]  tweak;
    logic [W-1:0] tk_data;
    logic         tk_valid, tk_first, tk_last, busy, done;
    logic [7:0]   tk_round, rc;
    beat_t        exp_q[$];
    int           hs_cnt  = 0;
    int           last_hs = 0;

    craft_tweakey_scheduler #(
      .DATA_W    (W),
      .NUM_ROUNDS(NR)
    ) u_dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .start_i   (start),
      .dec_i     (dec),
      .key_i     (key),
      .tweak_i   (tweak),
      .tk_data_o (tk_data),
      .tk_valid_o(tk_valid),
      .tk_ready_i(ready),
      .tk_first_o(tk_first),
      .tk_last_o (tk_last),
      .tk_round_o(tk_round),
      .rc_o      (rc),
      .busy_o    (busy),
      .done_o    (done)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      check_eq($sformatf("g%0d_%s", g, tag), got, exp);
    endtask

    // Consumer readiness changes just after each rising edge
    initial begin
      ready = 1'b1;
      forever begin
        @(posedge clk);
        #1;
        ready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end

    // Every valid beat (stalled or not) must equal the head of the expected stream
    initial begin
      beat_t gb;
      forever begin
        @(negedge clk);
        if (!rst && tk_valid) begin
          if (exp_q.size() == 0) begin
            chk("extra_beat", 1, 0);
          end else begin
            gb.round = tk_round;
            gb.rc    = rc;
            gb.first = tk_first;
            gb.last  = tk_last;
            gb.data  = 64'(tk_data);
            chk("beat", gb, exp_q[0]);
            if (ready) begin
              void'(exp_q.pop_front());
              hs_cnt++;
              last_hs = cyc;
            end
          end
        end
      end
    end

    task automatic build(input bit d, input logic [127:0] k, input logic [63:0] t);
      exp_q.delete();
      hs_cnt = 0;
      for (int i = 0; i < int'(NR); i++) begin
        int          r;
        logic [63:0] tk;
        r  = d ? int'(NR) - 1 - i : i;
        tk = tk_of(k, t, r);
        for (int bt = 0; bt < int'(B); bt++) begin
          beat_t e;
          e.round = 8'(r);
          e.rc    = rc_of(r);
          e.first = (bt == 0);
          e.last  = (bt == int'(B) - 1);
          e.data  = (tk << (bt * int'(W))) >> (64 - int'(W));
          exp_q.push_back(e);
        end
      end
    endtask

    task automatic run(input bit d, input logic [127:0] k, input logic [63:0] t, input bit stall,
                       input bit disturb);
      int n;
      build(d, k, t);
      stall_en = stall;
      start    = 1'b1;
      dec      = d;
      key      = k;
      tweak    = t;
      @(negedge clk);
      start = 1'b0;
      dec   = ~d;
      key   = ~k;
      tweak = ~t;
      chk("start_latency", tk_valid, 1);
      if (disturb) begin
        start = 1'b1;
        key   = rand128();
        tweak = {$urandom, $urandom};
        @(negedge clk);
        start = 1'b0;
      end
      n = 0;
      while (!done && n < int'(NR * B) * 4 + 50) begin
        @(negedge clk);
        n++;
      end
      chk("done_seen", done, 1);
      chk("beats_left", exp_q.size(), 0);
      chk("hs_count", hs_cnt, NR * B);
      chk("done_latency", cyc - last_hs, 1);
      if (disturb) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("done_once_busy_drop", {busy, done}, 0);
      stall_en = 1'b0;
    endtask

    initial begin
      int           n;
      logic [127:0] k;
      logic [63:0]  t;
      rst      = 1'b1;
      start    = 1'b0;
      dec      = 1'b0;
      key      = '0;
      tweak    = '0;
      stall_en = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {64'(tk_data), tk_valid, tk_first, tk_last, tk_round, rc, busy, done},
          0);
      rst = 1'b0;
      @(negedge clk);
      run(1'b0, 128'h0123456789abcdeffedcba9876543210, 64'h0, 1'b0, 1'b0);
      run(1'b0, 128'h0, 64'h0123456789abcdef, 1'b1, 1'b0);
      run(1'b1, 128'h0, 64'h0, 1'b0, 1'b0);
      run(1'b1, rand128(), {$urandom, $urandom}, 1'b1, 1'b1);
      run(1'b0, rand128(), {$urandom, $urandom}, 1'b1, 1'b1);

      // Abandon a run with reset part-way through
      k = rand128();
      t = {$urandom, $urandom};
      build(1'b0, k, t);
      start = 1'b1;
      key   = k;
      tweak = t;
      dec   = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_async", {64'(tk_data), tk_valid, tk_first, tk_last, tk_round, rc, busy, done}, 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      n   = 0;
      repeat (10) begin
        @(negedge clk);
        if (done || busy) n++;
      end
      chk("no_done_after_rst", n, 0);
      run(1'b0, rand128(), {$urandom, $urandom}, 1'b0, 1'b0);
      n_fin++;
    end
  end

  initial begin
    while (n_fin < 3 && cyc < 80000) @(negedge clk);
    if (n_fin < 3) check_eq("global_timeout", n_fin, 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
